// File: rtl/adc_mon_pkg.sv
// Shared definitions for the ADC sample monitor.
// Holds the default sample width, fault codes and window state encoding.
package adc_mon_pkg;

    localparam int SAMPLE_W_DEFAULT = 12;

    localparam logic [1:0] FC_NONE  = 2'b00;
    localparam logic [1:0] FC_OVER  = 2'b01;
    localparam logic [1:0] FC_UNDER = 2'b10;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } win_state_e;

endpackage

// File: rtl/moving_avg_window.sv
// Moving average over 2^LOG2_N samples (circular buffer + running sum).
// Ports: clk, rst (async, active-low), sample_in/sample_valid in;
//        avg_out (floor of window mean), avg_valid (one-cycle strobe) out.
module moving_avg_window
    import adc_mon_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEFAULT,
    parameter int LOG2_N   = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    output logic [SAMPLE_W-1:0] avg_out,
    output logic                avg_valid
);

    localparam int DEPTH = 1 << LOG2_N;
    localparam int SUM_W = SAMPLE_W + LOG2_N;

    logic [SAMPLE_W-1:0] mem_q [DEPTH];
    logic [LOG2_N-1:0]   wr_ptr_q;
    logic [LOG2_N-1:0]   fill_cnt_q;
    logic [SUM_W-1:0]    sum_q;
    logic [SUM_W-1:0]    sum_d;
    logic [SAMPLE_W-1:0] avg_q;
    logic                avg_valid_q;
    logic                avg_valid_d;
    win_state_e          state_q;
    win_state_e          state_d;

    always_comb begin
        // Intermediate may wrap mod 2^SUM_W; the result is exact because
        // the subtracted entry is always part of sum_q.
        sum_d = sum_q + SUM_W'(sample_in) - SUM_W'(mem_q[wr_ptr_q]);
        state_d = state_q;
        avg_valid_d = 1'b0;
        unique case (state_q)
            ST_FILL: begin
                if (sample_valid && (&fill_cnt_q)) begin
                    state_d = ST_RUN;
                    avg_valid_d = 1'b1;
                end
            end
            ST_RUN: begin
                avg_valid_d = sample_valid;
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            fill_cnt_q  <= '0;
            sum_q       <= '0;
            avg_q       <= '0;
            avg_valid_q <= 1'b0;
            state_q     <= ST_FILL;
        end else begin
            state_q     <= state_d;
            avg_valid_q <= avg_valid_d;
            if (sample_valid) begin
                mem_q[wr_ptr_q] <= sample_in;
                wr_ptr_q <= wr_ptr_q + LOG2_N'(1);
                sum_q    <= sum_d;
                avg_q    <= sum_d[SUM_W-1:LOG2_N];
                if (state_q == ST_FILL) begin
                    fill_cnt_q <= fill_cnt_q + LOG2_N'(1);
                end
            end
        end
    end

    assign avg_out   = avg_q;
    assign avg_valid = avg_valid_q;

endmodule

// File: rtl/adc_sample_monitor.sv
// ADC sample monitor: moving average, threshold check, sticky fault.
// Ports: clk, rst (async, active-low), sample_in/sample_valid,
//        thresh_hi/thresh_lo, fault_clr in; avg_out/avg_valid,
//        fault, fault_code (00 none, 01 over, 10 under) out.
module adc_sample_monitor
    import adc_mon_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEFAULT,
    parameter int LOG2_N   = 3,
    parameter int PERSIST  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] thresh_hi,
    input  logic [SAMPLE_W-1:0] thresh_lo,
    input  logic                fault_clr,
    output logic [SAMPLE_W-1:0] avg_out,
    output logic                avg_valid,
    output logic                fault,
    output logic [1:0]          fault_code
);

    localparam logic [3:0] PCNT = 4'(PERSIST);

    logic [3:0] viol_cnt_q;
    logic [3:0] viol_cnt_d;
    logic [1:0] last_type_q;
    logic [1:0] last_type_d;
    logic       fault_q;
    logic       fault_d;
    logic [1:0] code_q;
    logic [1:0] code_d;
    logic [1:0] vtype;

    moving_avg_window #(
        .SAMPLE_W (SAMPLE_W),
        .LOG2_N   (LOG2_N)
    ) u_win (
        .clk          (clk),
        .rst          (rst),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .avg_out      (avg_out),
        .avg_valid    (avg_valid)
    );

    always_comb begin
        // Over-range wins when a misconfigured window satisfies both.
        vtype = FC_NONE;
        if (avg_out > thresh_hi) begin
            vtype = FC_OVER;
        end else if (avg_out < thresh_lo) begin
            vtype = FC_UNDER;
        end

        viol_cnt_d  = viol_cnt_q;
        last_type_d = last_type_q;
        fault_d     = fault_q;
        code_d      = code_q;

        if (fault_clr) begin
            viol_cnt_d  = '0;
            last_type_d = FC_NONE;
            fault_d     = 1'b0;
            code_d      = FC_NONE;
        end else if (avg_valid) begin
            if (vtype == FC_NONE) begin
                viol_cnt_d = '0;
            end else begin
                if (vtype != last_type_q) begin
                    viol_cnt_d = 4'd1;
                end else if (viol_cnt_q >= PCNT) begin
                    viol_cnt_d = PCNT;
                end else begin
                    viol_cnt_d = viol_cnt_q + 4'd1;
                end
                last_type_d = vtype;
                // Code is frozen once the fault is latched.
                if (viol_cnt_d == PCNT && !fault_q) begin
                    fault_d = 1'b1;
                    code_d  = vtype;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            viol_cnt_q  <= '0;
            last_type_q <= FC_NONE;
            fault_q     <= 1'b0;
            code_q      <= FC_NONE;
        end else begin
            viol_cnt_q  <= viol_cnt_d;
            last_type_q <= last_type_d;
            fault_q     <= fault_d;
            code_q      <= code_d;
        end
    end

    assign fault      = fault_q;
    assign fault_code = code_q;

endmodule

// File: tb/tb_adc_sample_monitor.sv
// Directed bench for adc_sample_monitor (LOG2_N=2, PERSIST=3).
// Vector table plus hand sequences for back-to-back and reset cases.
module tb_adc_sample_monitor;
    import adc_mon_pkg::*;

    localparam int SW  = 12;
    localparam int L2  = 2;
    localparam int PER = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [SW-1:0] sample_in = '0;
    logic          sample_valid = 1'b0;
    logic [SW-1:0] thresh_hi = 12'd3000;
    logic [SW-1:0] thresh_lo = 12'd500;
    logic          fault_clr = 1'b0;
    logic [SW-1:0] avg_out;
    logic          avg_valid;
    logic          fault;
    logic [1:0]    fault_code;

    always #10 clk = ~clk;

    adc_sample_monitor #(
        .SAMPLE_W (SW),
        .LOG2_N   (L2),
        .PERSIST  (PER)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .thresh_hi    (thresh_hi),
        .thresh_lo    (thresh_lo),
        .fault_clr    (fault_clr),
        .avg_out      (avg_out),
        .avg_valid    (avg_valid),
        .fault        (fault),
        .fault_code   (fault_code)
    );

    typedef struct {
        logic          valid;
        logic [SW-1:0] smp;
        logic          clr;
        logic          ev;
        logic [SW-1:0] eavg;
        logic          ef;
        logic [1:0]    ec;
    } vec_t;

    vec_t vecs[$];
    int   n_chk = 0;
    int   n_bad = 0;

    function automatic vec_t V(input logic valid, input int smp,
                               input logic clr, input logic ev,
                               input int eavg, input logic ef,
                               input logic [1:0] ec);
        vec_t t;
        t.valid = valid;
        t.smp   = 12'(smp);
        t.clr   = clr;
        t.ev    = ev;
        t.eavg  = 12'(eavg);
        t.ef    = ef;
        t.ec    = ec;
        return t;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, " avg_out"}, int'(avg_out), 0);
        chk({nm, " avg_valid"}, int'(avg_valid), 0);
        chk({nm, " fault"}, int'(fault), 0);
        chk({nm, " fault_code"}, int'(fault_code), 0);
    endtask

    // One sample (or a lone clear pulse). With valid=1, clr is raised
    // in the avg_valid cycle so it meets the threshold evaluation.
    task automatic apply(input vec_t v, input string nm);
        @(negedge clk);
        sample_valid = v.valid;
        sample_in    = v.smp;
        fault_clr    = v.valid ? 1'b0 : v.clr;
        @(negedge clk);
        sample_valid = 1'b0;
        chk({nm, " avg_valid"}, int'(avg_valid), int'(v.ev));
        if (v.ev) begin
            chk({nm, " avg_out"}, int'(avg_out), int'(v.eavg));
        end
        fault_clr = v.valid ? v.clr : 1'b0;
        @(negedge clk);
        fault_clr = 1'b0;
        chk({nm, " fault"}, int'(fault), int'(v.ef));
        chk({nm, " fault_code"}, int'(fault_code), int'(v.ec));
    endtask

    initial begin
        int seqv[4];
        int seqa[4];
        seqv = '{100, 200, 300, 400};
        seqa = '{3096, 2122, 1173, 250};

        // Fill and first average
        vecs.push_back(V(1, 100, 0, 0, 0, 0, FC_NONE));
        vecs.push_back(V(1, 200, 0, 0, 0, 0, FC_NONE));
        vecs.push_back(V(1, 300, 0, 0, 0, 0, FC_NONE));
        vecs.push_back(V(1, 400, 0, 1, 250, 0, FC_NONE));
        // Oldest entry subtracted across the wrap
        vecs.push_back(V(1, 1000, 0, 1, 475, 0, FC_NONE));
        vecs.push_back(V(1, 1000, 0, 1, 675, 0, FC_NONE));
        vecs.push_back(V(1, 1000, 0, 1, 850, 0, FC_NONE));
        vecs.push_back(V(1, 1000, 0, 1, 1000, 0, FC_NONE));
        vecs.push_back(V(1, 0, 0, 1, 750, 0, FC_NONE));
        // Full scale, over-range persistence
        vecs.push_back(V(1, 4095, 0, 1, 1523, 0, FC_NONE));
        vecs.push_back(V(1, 4095, 0, 1, 2297, 0, FC_NONE));
        vecs.push_back(V(1, 4095, 0, 1, 3071, 0, FC_NONE));
        vecs.push_back(V(1, 4095, 0, 1, 4095, 0, FC_NONE));
        vecs.push_back(V(1, 4095, 0, 1, 4095, 1, FC_OVER));
        vecs.push_back(V(1, 4095, 0, 1, 4095, 1, FC_OVER));
        vecs.push_back(V(1, 4095, 0, 1, 4095, 1, FC_OVER));
        vecs.push_back(V(1, 4095, 0, 1, 4095, 1, FC_OVER));
        vecs.push_back(V(0, 0, 1, 0, 0, 0, FC_NONE));
        // Two over, then in range
        vecs.push_back(V(1, 2000, 0, 1, 3571, 0, FC_NONE));
        vecs.push_back(V(1, 2000, 0, 1, 3047, 0, FC_NONE));
        vecs.push_back(V(1, 2000, 0, 1, 2523, 0, FC_NONE));
        vecs.push_back(V(1, 2000, 0, 1, 2000, 0, FC_NONE));
        // Average equal to thresh_hi is in range
        vecs.push_back(V(1, 3000, 0, 1, 2250, 0, FC_NONE));
        vecs.push_back(V(1, 3000, 0, 1, 2500, 0, FC_NONE));
        vecs.push_back(V(1, 3000, 0, 1, 2750, 0, FC_NONE));
        vecs.push_back(V(1, 3000, 0, 1, 3000, 0, FC_NONE));
        // Average equal to thresh_lo is in range
        vecs.push_back(V(1, 500, 0, 1, 2375, 0, FC_NONE));
        vecs.push_back(V(1, 500, 0, 1, 1750, 0, FC_NONE));
        vecs.push_back(V(1, 500, 0, 1, 1125, 0, FC_NONE));
        vecs.push_back(V(1, 500, 0, 1, 500, 0, FC_NONE));
        // Under-range fault
        vecs.push_back(V(1, 0, 0, 1, 375, 0, FC_NONE));
        vecs.push_back(V(1, 0, 0, 1, 250, 0, FC_NONE));
        vecs.push_back(V(1, 0, 0, 1, 125, 1, FC_UNDER));
        vecs.push_back(V(1, 0, 0, 1, 0, 1, FC_UNDER));
        // Later over-range run leaves the code alone
        vecs.push_back(V(1, 4095, 0, 1, 1023, 1, FC_UNDER));
        vecs.push_back(V(1, 4095, 0, 1, 2047, 1, FC_UNDER));
        vecs.push_back(V(1, 4095, 0, 1, 3071, 1, FC_UNDER));
        vecs.push_back(V(1, 4095, 0, 1, 4095, 1, FC_UNDER));
        vecs.push_back(V(1, 4095, 0, 1, 4095, 1, FC_UNDER));
        vecs.push_back(V(0, 0, 1, 0, 0, 0, FC_NONE));
        // Clear coinciding with the third violation
        vecs.push_back(V(1, 4095, 0, 1, 4095, 0, FC_NONE));
        vecs.push_back(V(1, 4095, 0, 1, 4095, 0, FC_NONE));
        vecs.push_back(V(1, 4095, 1, 1, 4095, 0, FC_NONE));
        vecs.push_back(V(1, 4095, 0, 1, 4095, 0, FC_NONE));
        vecs.push_back(V(1, 4095, 0, 1, 4095, 0, FC_NONE));
        vecs.push_back(V(1, 4095, 0, 1, 4095, 1, FC_OVER));
        vecs.push_back(V(0, 0, 1, 0, 0, 0, FC_NONE));

        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("v%0d", i));
        end

        // Back-to-back samples on consecutive cycles
        @(negedge clk);
        sample_valid = 1'b1;
        sample_in    = 12'(seqv[0]);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("b2b%0d avg_valid", i), int'(avg_valid), 1);
            chk($sformatf("b2b%0d avg_out", i), int'(avg_out), seqa[i]);
            if (i < 3) begin
                sample_in = 12'(seqv[i + 1]);
            end else begin
                sample_valid = 1'b0;
            end
        end
        @(negedge clk);
        chk("b2b idle avg_valid", int'(avg_valid), 0);
        chk("b2b fault", int'(fault), 0);

        // Reset in RUN, then again mid-fill
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_zero("rst_run");
        rst = 1'b1;
        apply(V(1, 4000, 0, 0, 0, 0, FC_NONE), "mf0");
        apply(V(1, 4000, 0, 0, 0, 0, FC_NONE), "mf1");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_zero("rst_fill");
        rst = 1'b1;
        apply(V(1, 800, 0, 0, 0, 0, FC_NONE), "rf0");
        apply(V(1, 800, 0, 0, 0, 0, FC_NONE), "rf1");
        apply(V(1, 800, 0, 0, 0, 0, FC_NONE), "rf2");
        apply(V(1, 800, 0, 1, 800, 0, FC_NONE), "rf3");

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/adc_sample_monitor.md
Name: adc_sample_monitor

Overview:
Sits directly downstream of the ADC SPI controller and consumes its 12-bit sample stream.
Computes a moving average over 2^LOG2_N samples using a circular buffer and a running sum.
Compares each average against programmable high and low thresholds, with a persistence count.
Raises a sticky fault flag and fault code, which the twinning comparison logic uses for circuit-failure detection.

Parameters:
SAMPLE_W, 12, ADC sample width in bits.
LOG2_N, 3, log2 of the averaging window depth (DEPTH = 2^LOG2_N). Legal range 1..6.
PERSIST, 4, number of consecutive out-of-range averages needed to set the fault. Legal range 1..15.

Ports:
clk  in  1  50 MHz system clock.
rst  in  1  asynchronous reset, active-low.
sample_in  in  SAMPLE_W  sample word from the ADC controller.
sample_valid  in  1  one-cycle strobe: sample_in is new. No back-pressure.
thresh_hi  in  SAMPLE_W  upper limit. An average strictly greater than this value is over-range.
thresh_lo  in  SAMPLE_W  lower limit. An average strictly less than this value is under-range.
fault_clr  in  1  one-cycle pulse that clears the sticky fault.
avg_out  out  SAMPLE_W  latest window average.
avg_valid  out  1  one-cycle strobe: avg_out has been updated.
fault  out  1  sticky fault flag.
fault_code  out  2  00 none, 01 over-range, 10 under-range.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-low (rst == 0 resets).
- Reset values:
  - All outputs are 0.
  - Buffer entries, running sum, write pointer, fill count and viol_cnt are 0.
  - State is FILL.
- Circular buffer and running sum:
  - DEPTH entries of SAMPLE_W bits. wr_ptr is LOG2_N bits and wraps naturally from DEPTH-1 to 0.
  - sum is SAMPLE_W+LOG2_N bits wide and cannot overflow (max DEPTH*4095).
  - On each sample_valid: next_sum = sum + sample_in - buf[wr_ptr]. Then buf[wr_ptr] <= sample_in and wr_ptr <= wr_ptr + 1.
- Average: avg_out <= next_sum >> LOG2_N, which truncates (floor). Both are registered on the same edge, so latency is 1 cycle from sample_valid.
- State machine:
  - FILL: count samples. avg_valid stays 0. On the DEPTH-th sample, move to RUN; avg_valid pulses for that sample.
  - RUN: avg_valid pulses one cycle after every sample_valid. RUN exits only on reset.
- Threshold check: evaluated on the registered avg_out in the cycle where avg_valid = 1.
  - Over-range is checked first. If thresh_hi < thresh_lo (misconfigured) and both conditions hold, the result is over-range.
  - In range: viol_cnt <= 0.
  - Same violation type as the previous violation: viol_cnt increments, saturating at PERSIST.
  - Different type from the previous violation: viol_cnt <= 1 and the new type is recorded.
  - When viol_cnt reaches PERSIST: fault is set on the next edge (2 cycles after sample_valid) and fault_code latches the type.
- Sticky fault:
  - While fault = 1, later violations do not change fault_code.
  - fault_clr clears fault, fault_code and viol_cnt.
  - If fault_clr coincides with a violation evaluation, fault_clr has priority: fault stays 0 and viol_cnt becomes 0.
- Boundary conditions:
  - sample_valid on consecutive cycles must be accepted every cycle. Nominal rate is one sample per 400 us.
  - A sample equal to a threshold is in range.
  - rst asserted mid-operation, including mid-fill, restarts FILL with an empty buffer.

Decomposition:
- Package adc_mon_pkg holds:
  - SAMPLE_W default.
  - Fault code constants: FC_NONE = 2'b00, FC_OVER = 2'b01, FC_UNDER = 2'b10.
  - State encoding: ST_FILL, ST_RUN.
- One sub-module, moving_avg_window, holds the buffer, wr_ptr, sum, fill count, FILL/RUN state, avg_out and avg_valid.
- The top level holds the threshold compare, persistence counter and sticky fault.

Test Plan (LOG2_N=2, PERSIST=3, thresh_hi=3000, thresh_lo=500 unless stated):
1. After reset, send samples 100, 200, 300, 400 -> no avg_valid for the first three; avg_valid with avg_out = 250 one cycle after the fourth.
2. Send four samples of 1000, then one of 0 -> avg_out = 1000, then 750, confirming the oldest entry is subtracted across the wrap. Eight samples of 4095 -> avg_out = 4095 with no overflow.
3. Produce averages above 3000 for three consecutive outputs -> fault = 1, fault_code = 01 two cycles after the third sample_valid. Two over-range averages followed by one in range -> fault stays 0.
4. Averages below 500 for three consecutive outputs -> fault_code = 10. A further over-range run -> fault_code stays 10. A fault_clr pulse -> fault = 0, code = 00.
5. Assert fault_clr in the cycle of the third violation evaluation -> fault stays 0. Two more violations -> still 0. A third -> fault = 1.
6. Pull rst low after two samples -> all outputs are 0; the next four samples of 800 produce avg_valid only on the fourth, with avg_out = 800.
